// File: rtl/load_buffer.sv
// load_buffer: in-order load queue that issues one memory read at a time,
// extends the returned data by opcode and broadcasts it on the CDB.
module load_buffer #(
  parameter int ADDR_W = 32,
  parameter int ROB_W = 4,
  parameter int OP_W = 6,
  parameter int DEPTH = 8,
  parameter logic [OP_W-1:0] OP_LB = OP_W'(0),
  parameter logic [OP_W-1:0] OP_LH = OP_W'(1),
  parameter logic [OP_W-1:0] OP_LW = OP_W'(2),
  parameter logic [OP_W-1:0] OP_LBU = OP_W'(4),
  parameter logic [OP_W-1:0] OP_LHU = OP_W'(5)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              addrunit_lbuffer_en_in,
  input  logic [ADDR_W-1:0] addrunit_lbuffer_a_in,
  input  logic [ROB_W-1:0]  addrunit_lbuffer_dest_in,
  input  logic [OP_W-1:0]   addrunit_lbuffer_opcode_in,
  output logic              lbuffer_rs_full_out,
  output logic              lbuffer_mem_req_out,
  output logic [ADDR_W-1:0] lbuffer_mem_a_out,
  output logic [1:0]        lbuffer_mem_size_out,
  input  logic              mem_lbuffer_ack_in,
  input  logic [ADDR_W-1:0] mem_lbuffer_data_in,
  input  logic              rob_lbuffer_rst_in,
  output logic              lbuffer_cdb_en_out,
  output logic [ROB_W-1:0]  lbuffer_cdb_dest_out,
  output logic [ADDR_W-1:0] lbuffer_cdb_value_out
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ROB_W-1:0] dest_q [DEPTH];
  logic [OP_W-1:0] op_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0] count;
  logic pop, push, issue;
  logic [OP_W-1:0] head_op;
  logic [1:0] head_size;
  logic [ADDR_W-1:0] head_value, d;
  always_comb begin
    d = mem_lbuffer_data_in;
    head_op = op_q[head];
    head_size = (head_op == OP_LB || head_op == OP_LBU) ? 2'd0 :
                (head_op == OP_LH || head_op == OP_LHU) ? 2'd1 : 2'd2;
    head_value = head_op == OP_LB  ? {{(ADDR_W-8){d[7]}}, d[7:0]} :
                 head_op == OP_LBU ? {{(ADDR_W-8){1'b0}}, d[7:0]} :
                 head_op == OP_LH  ? {{(ADDR_W-16){d[15]}}, d[15:0]} :
                 head_op == OP_LHU ? {{(ADDR_W-16){1'b0}}, d[15:0]} : d;
    pop = state == S_WAIT && mem_lbuffer_ack_in;
    push = addrunit_lbuffer_en_in && (count != FULL_CNT || pop);
    issue = state == S_IDLE && count != '0;
    state_nxt = rob_lbuffer_rst_in ? S_IDLE : issue ? S_WAIT : pop ? S_IDLE : state;
  end
  assign lbuffer_rs_full_out = count == FULL_CNT;
  // Payload storage needs no reset; validity is tracked by head/tail/count.
  always_ff @(posedge clk_in)
    if (rdy_in && push && !rob_lbuffer_rst_in) begin
      addr_q[tail] <= addrunit_lbuffer_a_in;
      dest_q[tail] <= addrunit_lbuffer_dest_in;
      op_q[tail] <= addrunit_lbuffer_opcode_in;
    end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state <= S_IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      lbuffer_mem_req_out <= 1'b0;
      lbuffer_mem_a_out <= '0;
      lbuffer_mem_size_out <= '0;
      lbuffer_cdb_en_out <= 1'b0;
      lbuffer_cdb_dest_out <= '0;
      lbuffer_cdb_value_out <= '0;
    end else if (rdy_in) begin
      state <= state_nxt;
      if (rob_lbuffer_rst_in) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        lbuffer_mem_req_out <= 1'b0;
        lbuffer_cdb_en_out <= 1'b0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop) head <= head + 1'b1;
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
        lbuffer_cdb_en_out <= pop;
        if (issue) begin
          lbuffer_mem_req_out <= 1'b1;
          lbuffer_mem_a_out <= addr_q[head];
          lbuffer_mem_size_out <= head_size;
        end
        if (pop) begin
          lbuffer_mem_req_out <= 1'b0;
          lbuffer_cdb_dest_out <= dest_q[head];
          lbuffer_cdb_value_out <= head_value;
        end
      end
    end
endmodule
